hyperbus_cfg_regs_shadow: RTL

// - Next-generation HyperBus config register file: software writes land in SHADOW registers; ACTIVE copy
//   (drives cfg_o/chip_rules_o) updates atomically only while no transfer is in flight.
// - Replaces ready-stall-during-transfer with a commit FSM; adds commit/discard/lock control, status, commit counter.
// - Sits between the regbus config port and hyperbus PHY/address decoder.

---
 rtl/hyperbus_cfg_regs_shadow.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_cfg_regs_shadow.sv
// HyperBus config register file with shadow/active copies and a commit FSM.
// Define HYPERBUS_CFG_AUTOCOMMIT_EN to commit pending writes whenever no transfer is in flight.
package hyperbus_cfg_shadow_pkg;
  typedef struct packed {
    logic [3:0]  t_latency_access;
    logic        en_latency_additional;
    logic [15:0] t_burst_max;
    logic [3:0]  t_read_write_recovery;
    logic [3:0]  t_rx_clk_delay;
    logic [3:0]  t_tx_clk_delay;
    logic [4:0]  address_mask_msb;
    logic        address_space;
  } hyper_cfg_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;
endpackage

module hyperbus_cfg_regs_shadow
  import hyperbus_cfg_shadow_pkg::hyper_cfg_t;
#(
  parameter int unsigned NumChips       = 2,
  parameter int unsigned RegAddrWidth   = 32,
  parameter int unsigned RegDataWidth   = 32,
  parameter int unsigned CommitCntWidth = 16,
  parameter type reg_req_t = hyperbus_cfg_shadow_pkg::reg_req_t,
  parameter type reg_rsp_t = hyperbus_cfg_shadow_pkg::reg_rsp_t,
  parameter type rule_t    = hyperbus_cfg_shadow_pkg::rule_t,
  parameter logic [RegAddrWidth-1:0] RstChipBase  = 32'h8000_0000,
  parameter logic [RegAddrWidth-1:0] RstChipSpace = 32'h0400_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  reg_req_t                 reg_req_i,
  output reg_rsp_t                 reg_rsp_o,
  input  logic                     trans_active_i,
  output hyper_cfg_t               cfg_o,
  output rule_t [NumChips-1:0]     chip_rules_o,
  output logic                     pending_o,
  output logic                     cfg_update_o
);

  localparam int unsigned NumRegs = 10 + 2 * NumChips;
  localparam int unsigned IdxW    = $clog2(NumRegs);
  localparam int unsigned IdxLsb  = $clog2(RegDataWidth / 8);

`ifdef HYPERBUS_CFG_AUTOCOMMIT_EN
  localparam bit AutoCommit = 1'b1;
`else
  localparam bit AutoCommit = 1'b0;
`endif

  localparam hyper_cfg_t RstCfg = '{
    t_latency_access:      4'd6,
    en_latency_additional: 1'b0,
    t_burst_max:           16'd350,
    t_read_write_recovery: 4'd6,
    t_rx_clk_delay:        4'd8,
    t_tx_clk_delay:        4'd8,
    address_mask_msb:      5'd25,
    address_space:         1'b0
  };

  typedef enum logic [1:0] {StIdle, StPending, StArmed, StCommit} state_e;

  typedef logic [NumChips-1:0][1:0][RegDataWidth-1:0] ranges_t;

  state_e                    state_q;
  hyper_cfg_t                cfg_sh_q, cfg_act_q, cfg_wr;
  ranges_t                   rng_sh_q, rng_act_q, rng_wr, rng_rst;
  logic                      lock_q, pending_q, cfg_update_q;
  logic [CommitCntWidth-1:0] cnt_q;

  logic [IdxW-1:0]         reg_idx;
  int unsigned             idx_u;
  logic [RegDataWidth-1:0] rd_val, wmask, merged;
  logic is_cfg, is_ctrl, is_stat, is_rng, unmapped;
  logic ready, accepted, sh_wr, ctrl_wr, do_commit, do_lock, do_discard;
  logic unused_addr;

  assign reg_idx     = reg_req_i.addr[IdxLsb +: IdxW];
  assign unused_addr = ^reg_req_i.addr;

  always_comb begin
    for (int unsigned i = 0; i < NumChips; i++) begin
      rng_rst[i][0] = RegDataWidth'(RstChipBase + RstChipSpace * i);
      rng_rst[i][1] = RegDataWidth'(RstChipBase + RstChipSpace * (i + 1));
    end
  end

  // Address decode and shadow read mux
  always_comb begin
    idx_u    = 32'(reg_idx);
    is_cfg   = idx_u < 8;
    is_ctrl  = idx_u == 8;
    is_stat  = idx_u == 9;
    is_rng   = (idx_u >= 10) && (idx_u < NumRegs);
    unmapped = idx_u >= NumRegs;
    rd_val   = '0;
    case (idx_u)
      0: rd_val = RegDataWidth'(cfg_sh_q.t_latency_access);
      1: rd_val = RegDataWidth'(cfg_sh_q.en_latency_additional);
      2: rd_val = RegDataWidth'(cfg_sh_q.t_burst_max);
      3: rd_val = RegDataWidth'(cfg_sh_q.t_read_write_recovery);
      4: rd_val = RegDataWidth'(cfg_sh_q.t_rx_clk_delay);
      5: rd_val = RegDataWidth'(cfg_sh_q.t_tx_clk_delay);
      6: rd_val = RegDataWidth'(cfg_sh_q.address_mask_msb);
      7: rd_val = RegDataWidth'(cfg_sh_q.address_space);
      8: rd_val[1] = lock_q;
      9: begin
        rd_val[0]                   = pending_q;
        rd_val[1]                   = lock_q;
        rd_val[16 +: CommitCntWidth] = cnt_q;
      end
      default: ;
    endcase
    for (int unsigned i = 0; i < NumChips; i++) begin
      if (idx_u == 10 + 2 * i) rd_val = rng_sh_q[i][0];
      if (idx_u == 11 + 2 * i) rd_val = rng_sh_q[i][1];
    end
  end

  // Byte-masked merge onto the current shadow value, truncated per field
  always_comb begin
    for (int unsigned b = 0; b < RegDataWidth / 8; b++) begin
      wmask[8*b +: 8] = {8{reg_req_i.wstrb[b]}};
    end
    merged = (rd_val & ~wmask) | (reg_req_i.wdata & wmask);
    cfg_wr = cfg_sh_q;
    case (idx_u)
      0: cfg_wr.t_latency_access      = merged[3:0];
      1: cfg_wr.en_latency_additional = merged[0];
      2: cfg_wr.t_burst_max           = merged[15:0];
      3: cfg_wr.t_read_write_recovery = merged[3:0];
      4: cfg_wr.t_rx_clk_delay        = merged[3:0];
      5: cfg_wr.t_tx_clk_delay        = merged[3:0];
      6: cfg_wr.address_mask_msb      = merged[4:0];
      7: cfg_wr.address_space         = merged[0];
      default: ;
    endcase
    rng_wr = rng_sh_q;
    for (int unsigned i = 0; i < NumChips; i++) begin
      if (idx_u == 10 + 2 * i) rng_wr[i][0] = merged;
      if (idx_u == 11 + 2 * i) rng_wr[i][1] = merged;
    end
  end

  always_comb begin
    ready      = state_q != StCommit;
    accepted   = reg_req_i.valid && ready;
    sh_wr      = accepted && reg_req_i.write && (is_cfg || is_rng) && !lock_q;
    ctrl_wr    = accepted && reg_req_i.write && is_ctrl && reg_req_i.wstrb[0];
    do_commit  = ctrl_wr && reg_req_i.wdata[0];
    do_lock    = ctrl_wr && reg_req_i.wdata[1];
    do_discard = ctrl_wr && reg_req_i.wdata[2];
    reg_rsp_o       = '0;
    reg_rsp_o.ready = ready;
    reg_rsp_o.rdata = rd_val;
    reg_rsp_o.error = accepted && (unmapped ||
                      (reg_req_i.write && (is_stat || (lock_q && (is_cfg || is_rng)))));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cfg_sh_q     <= RstCfg;
      cfg_act_q    <= RstCfg;
      rng_sh_q     <= rng_rst;
      rng_act_q    <= rng_rst;
      lock_q       <= 1'b0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      cfg_update_q <= 1'b0;
    end else begin
      cfg_update_q <= 1'b0;
      if (sh_wr) begin
        cfg_sh_q <= cfg_wr;
        rng_sh_q <= rng_wr;
      end
      if (do_lock) lock_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (sh_wr) begin
            state_q   <= StPending;
            pending_q <= 1'b1;
          end
        end
        StPending, StArmed: begin
          // Discard takes priority over commit and arming
          if (do_discard) begin
            cfg_sh_q  <= cfg_act_q;
            rng_sh_q  <= rng_act_q;
            state_q   <= StIdle;
            pending_q <= 1'b0;
          end else if (state_q == StArmed || AutoCommit) begin
            if (!trans_active_i) state_q <= StCommit;
          end else if (do_commit) begin
            state_q <= StArmed;
          end
        end
        StCommit: begin
          cfg_act_q    <= cfg_sh_q;
          rng_act_q    <= rng_sh_q;
          cnt_q        <= cnt_q + 1'b1;
          state_q      <= StIdle;
          pending_q    <= 1'b0;
          cfg_update_q <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_o = cfg_act_q;
    for (int unsigned i = 0; i < NumChips; i++) begin
      chip_rules_o[i]            = '0;
      chip_rules_o[i].idx        = i;
      chip_rules_o[i].start_addr = rng_act_q[i][0];
      chip_rules_o[i].end_addr   = rng_act_q[i][1];
    end
  end

  assign pending_o    = pending_q;
  assign cfg_update_o = cfg_update_q;

endmodule
